// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Captures a signed result, converts its magnitude to BCD (shift-add-3, one
//   bit per cycle), loads a digit buffer with 7-segment codes one entry per
//   cycle, and scans four anodes of a page of that buffer continuously.
//
//   Build option: SEG_LEADING_ZERO_BLANK_EN -- when defined, zero digits above
//   the most significant nonzero digit are loaded as blank instead of 0.
//
//   Ports
//     CLK        in   clock, rising edge
//     RST        in   synchronous active-high reset
//     i_val      in   DATA_W signed value to display
//     i_valid    in   one-cycle capture strobe (accepted in IDLE/SHOW)
//     error      in   error flag captured with i_valid
//     but0       in   page button level (already debounced)
//     led_active out  anode enables, active-low
//     led_code   out  segment code, active-low, bit7 = dp
//     stage_led  out  one-hot page indicator
//     busy       out  high during conversion and buffer load
//     done       out  one-cycle pulse when the buffer load completes
//
//   state | meaning
//   IDLE  | no result captured since reset
//   CONV  | BCD conversion, DATA_W cycles
//   LOAD  | writing digit buffer entries 0..NUM_DIGITS-1
//   SHOW  | result displayed, new capture allowed
module seg_scan_display #(
    parameter int DATA_W      = 16,
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] i_val,
    input  logic              i_valid,
    input  logic              error,
    input  logic              but0,
    output logic [3:0]        led_active,
    output logic [7:0]        led_code,
    output logic [3:0]        stage_led,
    output logic              busy,
    output logic              done
);
    // Decimal digits needed for magnitudes up to 2^(DATA_W-1) (log10(2) < 0.302).
    localparam int BCD_D   = (DATA_W * 302) / 1000 + 1;
    localparam int BCD_W   = 4 * BCD_D;
    localparam int DIG_ALL = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS;
    localparam int CNT_MAX = (DATA_W > NUM_DIGITS) ? DATA_W : NUM_DIGITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int NPAGE   = NUM_DIGITS / 4;
    localparam int PG_W    = (NPAGE > 1) ? $clog2(NPAGE) : 1;
    localparam int RC_W    = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_LOAD, S_SHOW} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0]    shreg_q;
    logic [BCD_W-1:0]     bcd_q, bcd_adj;
    logic                 neg_q, err_q, done_q, but0_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [7:0]           dbuf_q [NUM_DIGITS];
    logic [RC_W-1:0]      ref_q;
    logic [1:0]           anode_q;
    logic [PG_W-1:0]      page_q;
    logic [3:0]           led_active_q, stage_led_q;
    logic [7:0]           led_code_q;

    logic                 capture, conv_last, load_last, ovf;
    logic [DATA_W:0]      val_ext, mag;
    logic [IDX_W-1:0]     cnt_idx, rd_idx;
    logic [4*DIG_ALL-1:0] bcd_pad;
    logic [3:0]           digit;
    logic [7:0]           load_code;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    assign capture   = i_valid && (state_q == S_IDLE || state_q == S_SHOW);
    assign conv_last = (cnt_q == '0);
    assign load_last = (cnt_q == CNT_W'(NUM_DIGITS - 1));

    // One extra bit so that -2^(DATA_W-1) negates without wrapping.
    assign val_ext = {i_val[DATA_W-1], i_val};
    assign mag     = val_ext[DATA_W] ? (~val_ext + (DATA_W+1)'(1)) : val_ext;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_SHOW: if (i_valid)   state_d = S_CONV;
            S_CONV:         if (conv_last) state_d = S_LOAD;
            S_LOAD:         if (load_last) state_d = S_SHOW;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_D; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_pad = (4*DIG_ALL)'(bcd_q);
    assign cnt_idx = cnt_q[IDX_W-1:0];
    assign digit   = bcd_pad[{cnt_idx, 2'b00} +: 4];

    // A nonzero digit at or above the sign position cannot be shown.
    always_comb begin
        ovf = 1'b0;
        for (int i = NUM_DIGITS - 1; i < DIG_ALL; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) ovf = 1'b1;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [4*DIG_ALL-1:0] bcd_upper;
    assign bcd_upper = bcd_pad >> {cnt_idx, 2'b00};
`endif

    always_comb begin
        load_code = 8'hFF;
        if (err_q) begin
            if (cnt_q == CNT_W'(2))     load_code = 8'h86;
            else if (cnt_q < CNT_W'(2)) load_code = 8'hAF;
        end else if (ovf || (neg_q && load_last)) begin
            load_code = 8'hBF;
        end else begin
            load_code = seg7(digit);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (cnt_q != '0 && bcd_upper == '0) load_code = 8'hFF;
`endif
        end
    end

    assign rd_idx = IDX_W'({page_q, anode_q});

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bcd_q        <= '0;
            neg_q        <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            but0_q       <= 1'b0;
            ref_q        <= '0;
            anode_q      <= 2'd0;
            page_q       <= '0;
            led_active_q <= 4'b1110;
            led_code_q   <= 8'hFF;
            stage_led_q  <= 4'b0001;
            for (int i = 0; i < NUM_DIGITS; i++) dbuf_q[i] <= 8'hFF;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_LOAD) && load_last;

            if (capture) begin
                // Top magnitude bit is pre-shifted into the BCD register,
                // leaving exactly DATA_W shift-add-3 steps.
                shreg_q <= mag[DATA_W-1:0];
                bcd_q   <= BCD_W'(mag[DATA_W]);
                neg_q   <= i_val[DATA_W-1];
                err_q   <= error;
                cnt_q   <= CNT_W'(DATA_W - 1);
            end else if (state_q == S_CONV) begin
                bcd_q   <= (bcd_adj << 1) | BCD_W'(shreg_q[DATA_W-1]);
                shreg_q <= shreg_q << 1;
                cnt_q   <= conv_last ? '0 : cnt_q - CNT_W'(1);
            end else if (state_q == S_LOAD) begin
                dbuf_q[cnt_idx] <= load_code;
                if (!load_last) cnt_q <= cnt_q + CNT_W'(1);
            end

            if (ref_q == RC_W'(REFRESH_DIV - 1)) begin
                ref_q   <= '0;
                anode_q <= anode_q + 2'd1;
            end else begin
                ref_q <= ref_q + RC_W'(1);
            end

            but0_q <= but0;
            if (but0 && !but0_q) begin
                if (page_q == PG_W'(NPAGE - 1)) page_q <= '0;
                else                            page_q <= page_q + PG_W'(1);
            end

            led_active_q <= ~(4'b0001 << anode_q);
            led_code_q   <= dbuf_q[rd_idx];
            stage_led_q  <= (int'(page_q) < 4) ? (4'b0001 << page_q) : 4'b0000;
        end
    end

    assign busy       = (state_q == S_CONV) || (state_q == S_LOAD);
    assign done       = done_q;
    assign led_active = led_active_q;
    assign led_code   = led_code_q;
    assign stage_led  = stage_led_q;
endmodule
